// File: rtl/reg_write_arbiter_if.sv
// Requester-side write bus shared by N_REQ requesters: packed per-requester
// valid/lock/addr/data going in, one-hot ready coming back.
interface reg_write_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 2
);
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ-1:0]        req_lock;
    logic [N_REQ*ADDR_W-1:0] req_addr;
    logic [N_REQ*WIDTH-1:0]  req_data;
    logic [N_REQ-1:0]        req_ready;

    modport master (
        output req_valid,
        output req_lock,
        output req_addr,
        output req_data,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_lock,
        input  req_addr,
        input  req_data,
        output req_ready
    );
endinterface

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter feeding the single write port of a DFF register bank,
// with an optional bounded lock that gives one requester a back-to-back burst.
module reg_write_arbiter #(
    parameter int N_REQ    = 4,
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 4,
    parameter int ADDR_W   = 2,
    parameter int LOCK_MAX = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    reg_write_arbiter_if.slave       bus,
    output logic [DEPTH*WIDTH-1:0]   reg_q,
    output logic                     gnt_valid,
    output logic [$clog2(N_REQ)-1:0] gnt_id,
    output logic                     locked,
    output logic                     addr_err
);
    localparam int ID_W  = $clog2(N_REQ);
    localparam int CNT_W = $clog2(LOCK_MAX + 1);

    typedef enum logic {ARB, LOCKED} state_t;

    state_t           state_reg;
    logic [ID_W-1:0]  rr_ptr_reg;
    logic [ID_W-1:0]  owner_reg;
    logic [CNT_W-1:0] lock_cnt_reg;

    logic             rr_found;
    logic [ID_W-1:0]  rr_winner;
    logic             grant_any;
    logic [ID_W-1:0]  grant_id;
    logic [N_REQ-1:0] ready_vec;
    logic [ADDR_W-1:0] beat_addr;
    logic [WIDTH-1:0] beat_data;
    logic             beat_addr_ok;
    logic             burst_full;

    // Scan starts just after the last winner so every requester gets a turn.
    always_comb begin
        int idx;
        idx       = 0;
        rr_found  = 1'b0;
        rr_winner = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = (int'(rr_ptr_reg) + k) % N_REQ;
            if (!rr_found && bus.req_valid[idx]) begin
                rr_found  = 1'b1;
                rr_winner = ID_W'(idx);
            end
        end
    end

    always_comb begin
        if (state_reg == LOCKED) begin
            grant_id  = owner_reg;
            grant_any = bus.req_valid[owner_reg];
        end else begin
            grant_id  = rr_winner;
            grant_any = rr_found;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_ready
            assign ready_vec[gi] = grant_any && (grant_id == ID_W'(gi));
        end
    endgenerate

    assign bus.req_ready  = ready_vec;
    assign beat_addr      = bus.req_addr[int'(grant_id)*ADDR_W +: ADDR_W];
    assign beat_data      = bus.req_data[int'(grant_id)*WIDTH +: WIDTH];
    assign beat_addr_ok   = ({1'b0, beat_addr} < (ADDR_W+1)'(DEPTH));
    assign burst_full     = (lock_cnt_reg + CNT_W'(1)) >= CNT_W'(LOCK_MAX);
    assign locked         = (state_reg == LOCKED);

    // Out-of-range beats are still accepted; they just never hit a register.
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_bank
            logic [WIDTH-1:0] q_reg;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    q_reg <= '0;
                end else if (grant_any && beat_addr_ok && (beat_addr == ADDR_W'(gi))) begin
                    q_reg <= beat_data;
                end
            end
            assign reg_q[gi*WIDTH +: WIDTH] = q_reg;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ARB;
            rr_ptr_reg   <= ID_W'(N_REQ - 1);
            owner_reg    <= '0;
            lock_cnt_reg <= '0;
            gnt_valid    <= 1'b0;
            gnt_id       <= '0;
            addr_err     <= 1'b0;
        end else begin
            gnt_valid <= grant_any;
            addr_err  <= grant_any && !beat_addr_ok;
            if (grant_any) begin
                rr_ptr_reg <= grant_id;
                gnt_id     <= grant_id;
            end
            case (state_reg)
                ARB: begin
                    if (grant_any && bus.req_lock[grant_id] && (LOCK_MAX > 1)) begin
                        state_reg    <= LOCKED;
                        owner_reg    <= grant_id;
                        lock_cnt_reg <= CNT_W'(1);
                    end
                end
                LOCKED: begin
                    // Release on an unlocked beat, a full burst, or an idle owner that let go.
                    if (grant_any) begin
                        if (!bus.req_lock[owner_reg] || burst_full) begin
                            state_reg    <= ARB;
                            lock_cnt_reg <= '0;
                        end else begin
                            lock_cnt_reg <= lock_cnt_reg + CNT_W'(1);
                        end
                    end else if (!bus.req_lock[owner_reg]) begin
                        state_reg    <= ARB;
                        lock_cnt_reg <= '0;
                    end
                end
                default: begin
                    state_reg    <= ARB;
                    lock_cnt_reg <= '0;
                end
            endcase
        end
    end
endmodule

// File: doc/reg_write_arbiter.md
Name: reg_write_arbiter

Overview:
- Shares the single write port of a small D-flip-flop register bank between N_REQ requesters.
- Uses round-robin arbitration with a valid/ready handshake.
- An optional lock lets one requester issue a back-to-back burst of writes without interleaving.
- Each accepted write lands in the bank on the accepting clock edge and is visible on reg_q one cycle later, matching plain DFF timing.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- WIDTH, 8, data width of each register
- DEPTH, 4, number of registers in the bank (1..2**ADDR_W)
- ADDR_W, 2, register address width
- LOCK_MAX, 4, maximum accepted beats per locked burst before forced release (>=1)

Ports:
- clk  in  1  clock; rising edge active
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  N_REQ  per-requester write request
- req_lock  in  N_REQ  per-requester request to hold the grant after this beat
- req_addr  in  N_REQ*ADDR_W  packed addresses; requester i at [i*ADDR_W +: ADDR_W]
- req_data  in  N_REQ*WIDTH  packed write data; requester i at [i*WIDTH +: WIDTH]
- req_ready  out  N_REQ  one-hot or zero, combinational; a beat is accepted when valid&ready
- reg_q  out  DEPTH*WIDTH  register bank contents; reg j at [j*WIDTH +: WIDTH]
- gnt_valid  out  1  registered; 1 for one cycle after any accepted beat
- gnt_id  out  $clog2(N_REQ)  registered; index of the last accepted requester
- locked  out  1  registered; FSM is in LOCKED
- addr_err  out  1  registered one-cycle pulse; an accepted beat had addr >= DEPTH

Behaviour:
- Reset (async, rst_n=0): reg_q=0, gnt_valid=0, gnt_id=0, locked=0, addr_err=0, state=ARB, rr_ptr=N_REQ-1 (requester 0 has highest priority), lock_cnt=0. Reset mid-burst abandons the lock; no partial write occurs on the reset edge.
- ARB state: winner = first i with req_valid[i], scanning rr_ptr+1, rr_ptr+2, ... modulo N_REQ. req_ready[winner]=1, all others 0. With no valid request, req_ready=0.
- req_ready may depend combinationally on req_valid. Requesters must not make req_valid depend on req_ready.
- On an accepted beat (rising edge):
  - If addr < DEPTH, reg[addr] <= data.
  - rr_ptr <= winner.
  - gnt_valid <= 1, gnt_id <= winner.
  - If addr >= DEPTH, no write and addr_err <= 1; the beat is still accepted (ready is not withheld).
- ARB->LOCKED: the accepted beat has req_lock[winner]=1 and LOCK_MAX>1. Capture owner=winner; lock_cnt <= 1.
- LOCKED state: only the owner is a candidate. req_ready[owner]=req_valid[owner]; all others 0. Other requesters stall without loss.
- LOCKED->ARB on the first of:
  - An accepted owner beat with req_lock=0.
  - An accepted owner beat that makes lock_cnt reach LOCK_MAX (forced release; that beat is still written).
  - A cycle where the owner has req_valid=0 and req_lock=0 (no beat).
- The release beat updates rr_ptr=owner, so the next ARB cycle favours owner+1.
- lock_cnt increments on each accepted beat in LOCKED and clears on exit.
- An owner with valid=0 and lock=1 holds LOCKED indefinitely. This is by design; the system must bound it.
- Cycles with no accepted beat: gnt_valid <= 0, addr_err <= 0, gnt_id holds, and reg_q holds.
- Simultaneous requests to the same address from different requesters cannot occur, since only one beat is accepted per cycle.
- Writes in consecutive cycles to the same register: reg_q shows each value for exactly one cycle.
- rr_ptr wraps from N_REQ-1 to 0.
- Inputs are sampled only at the rising edge. There is no combinational path from req_* to reg_q, gnt_*, locked or addr_err.

Test Plan:
- Reset then req_valid=4'b1111 held for 4 cycles, addr=i, data=8'hA0+i → grants in order 0,1,2,3 (gnt_id one cycle late). Final reg_q = {A3,A2,A1,A0}; each req_ready is one-hot.
- Req 2 alone writes addr 1 = 8'h5C → req_ready=4'b0100 in the same cycle. reg_q[15:8]=5C on the next cycle, gnt_valid pulses once, gnt_id=2.
- Req 1 with lock=1 for 6 beats while req 3 is valid, LOCK_MAX=4 → req 1 gets 4 consecutive beats and locked=1 during beats 2-4. Forced release follows, then req 3 is granted next, and req 1 resumes after.
- Req 0 locked, then drops both valid and lock with req 2 pending → locked clears and req 2 is granted in the following ARB cycle.
- Beat with addr=3 while DEPTH=3 → accepted (ready=1), addr_err=1 for one cycle, reg_q unchanged.
- Assert rst_n=0 asynchronously mid-burst between edges → all outputs 0 immediately. After release, requester 0 has priority and locked=0.
